transmission8_link: RTL and testbench
=====================================

Name: transmission8_link

Overview:
- 8-channel serial-select data transmission block: a 74151-style 8:1 data selector followed by a 74138-style 1:8 data distributor.
- The three select lines {C,B,A} choose channel n. Bit iData[n] is sent over a single internal line and delivered to oData[n].
- Every unselected output sits at the idle level (logic 1).
- Output is registered, one clock domain. Used as the channel-routing stage between a parallel source and parallel sink.

Parameters:
- WIDTH, 8, number of channels (power of two; only 8 required for this block).
- SEL_W, 3, select width, derived as clog2(WIDTH); must not be overridden independently.
- IDLE_LEVEL, 1'b1, level driven on unselected outputs and on all outputs during reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- iData  input  WIDTH  parallel source channels.
- A  input  1  select bit 0 (LSB).
- B  input  1  select bit 1.
- C  input  1  select bit 2 (MSB).
- oData  output  WIDTH  distributed channels, registered.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- sel = {C,B,A}, unsigned 0..7; A is LSB.
- Mux stage (combinational): line = iData[sel].
- Demux stage (combinational): next[i] = line when i == sel, otherwise IDLE_LEVEL, for all i.
- Output register:
  - Rising clk with rst=1: oData <= {WIDTH{IDLE_LEVEL}} (8'hFF).
  - Rising clk with rst=0: oData <= next.
- Latency: exactly 1 cycle from iData/A/B/C sampled at edge k to oData valid after edge k. No handshake; a new channel can be selected every cycle.
- Exactly one output bit is data-bearing per cycle.
- iData=8'hFF gives oData=8'hFF regardless of sel. oData[sel] is 0 only when iData[sel]=0.
- Simultaneous change of data and select: both sampled at the same edge; no glitch is visible on oData because it is registered.
- Reset mid-operation: oData forced to 8'hFF at the first edge with rst=1 and held while rst=1. Normal routing resumes at the first edge with rst=0, using the inputs sampled at that edge.
- Reset overrides all inputs.
- No X-propagation handling required; inputs are assumed driven.
- Output is defined only from the first clock edge; initial value before any edge is not specified.

Decomposition:
- Shared package holds:
  - localparam CH_W = 8 and SEL_W = 3.
  - typedef sel_t (logic [2:0]).
  - typedef chan_t (logic [7:0]).
  - IDLE_LEVEL constant, IDLE_WORD = 8'hFF.
- One natural sub-module: transmission8_demux, a combinational 1:WIDTH distributor (inputs line, sel; output WIDTH bits with idle fill).
- The 8:1 selector and the output register stay in the top.

Test Plan:
- Reset: rst=1 for 2 cycles with iData=8'h00, sel=3 -> oData=8'hFF after the first edge and held.
- All-ones sweep: iData=8'hFF, A toggling every 40ns, B every 80ns, C every 20/40ns pattern, rst=0 -> oData=8'hFF every cycle.
- Single zero routing: iData=8'hFE, sel=0 -> oData=8'hFE. Same data with sel=1 -> 8'hFF.
- Channel 5: iData=8'h00, C=1 B=0 A=1 -> oData=8'hDF one cycle later. Change to sel=7 -> oData=8'h7F the next cycle.
- Pattern sweep: iData=8'h55, sel 0..7 one per cycle -> oData sequence FF, FD, FF, F7, FF, DF, FF, 7F, each lagging its select by exactly 1 cycle.
- Reset mid-stream: during the 8'h55 sweep at sel=3, assert rst for 1 cycle -> oData=8'hFF that cycle. Release with sel=5 -> oData=8'hDF on the next edge.

Source files
------------

// File: rtl/transmission8_link_pkg.sv
// Shared widths, types and idle constants for the 8-channel select/distribute link.
package transmission8_link_pkg;
  localparam int CH_W = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [CH_W-1:0]  chan_t;

  localparam logic  IDLE_LEVEL = 1'b1;
  localparam chan_t IDLE_WORD  = 8'hFF;
endpackage

// File: rtl/transmission8_link_demux.sv
// Combinational 1:WIDTH distributor: the selected output carries line, all others idle.
module transmission8_demux #(
  parameter int   WIDTH      = 8,
  parameter int   SEL_W      = 3,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             line,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out      = {WIDTH{IDLE_LEVEL}};
    out[sel] = line;
  end

endmodule

// File: rtl/transmission8_link.sv
// 8:1 selector feeding a 1:8 distributor over a single line, with a registered output.
module transmission8_link
  import transmission8_link_pkg::*;
#(
  parameter int   WIDTH      = CH_W,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] iData,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  output logic [WIDTH-1:0] oData
);

  // Select width follows the channel count so the two can never disagree.
  localparam int SEL_W_L = $clog2(WIDTH);

  logic [SEL_W_L-1:0] sel_p0;
  logic               line_p0;
  logic [WIDTH-1:0]   next_p0;
  logic [WIDTH-1:0]   data_p1;

  assign sel_p0  = {C, B, A};
  assign line_p0 = iData[sel_p0];

  transmission8_demux #(
    .WIDTH      (WIDTH),
    .SEL_W      (SEL_W_L),
    .IDLE_LEVEL (IDLE_LEVEL)
  ) u_demux (
    .line (line_p0),
    .sel  (sel_p0),
    .out  (next_p0)
  );

  // p0 -> p1: output register, forced to idle while in reset
  always_ff @(posedge clk) begin
    if (rst) data_p1 <= {WIDTH{IDLE_LEVEL}};
    else     data_p1 <= next_p0;
  end

  assign oData = data_p1;

endmodule

// File: tb/tb_transmission8_link.sv
// Directed table-driven bench for the 8-channel select/distribute link.
module tb_transmission8_link;
  import transmission8_link_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  chan_t iData;
  logic  A, B, C;
  chan_t oData;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic  rst;
    chan_t data;
    sel_t  sel;
    chan_t exp;
    string name;
  } vec_t;

  vec_t vecs[$];

  transmission8_link dut (
    .clk   (clk),
    .rst   (rst),
    .iData (iData),
    .A     (A),
    .B     (B),
    .C     (C),
    .oData (oData)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input chan_t d, input sel_t s, input chan_t e, input string nm);
    vec_t v;
    v.rst = r; v.data = d; v.sel = s; v.exp = e; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input chan_t act, input chan_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive inputs just after a rising edge, confirm the output still holds the
  // previous result, then check the new result after the next rising edge.
  task automatic step(input logic r, input chan_t d, input sel_t s, input chan_t e,
                      input string nm, input logic have_prev, input chan_t prev);
    rst = r; iData = d; {C, B, A} = s;
    #1;
    if (have_prev) check({nm, "_hold"}, oData, prev);
    @(posedge clk);
    #1;
    check(nm, oData, e);
  endtask

  initial begin
    chan_t prev;
    logic  have_prev;
    rst = 1'b1; iData = 8'h00; {C, B, A} = 3'd3;
    @(posedge clk); #1;

    // Reset held with data 00, sel 3
    add(1'b1, 8'h00, 3'd3, 8'hFF, "rst_a");
    add(1'b1, 8'h00, 3'd3, 8'hFF, "rst_b");
    // All-ones: every channel stays idle-high
    for (int s = 0; s < 8; s++) add(1'b0, 8'hFF, sel_t'(s), 8'hFF, $sformatf("ones_s%0d", s));
    // Single zero on channel 0
    add(1'b0, 8'hFE, 3'd0, 8'hFE, "fe_s0");
    add(1'b0, 8'hFE, 3'd1, 8'hFF, "fe_s1");
    // Channel 5 then 7 with all-zero data
    add(1'b0, 8'h00, 3'd5, 8'hDF, "z_s5");
    add(1'b0, 8'h00, 3'd7, 8'h7F, "z_s7");
    // 55 sweep
    add(1'b0, 8'h55, 3'd0, 8'hFF, "p55_s0");
    add(1'b0, 8'h55, 3'd1, 8'hFD, "p55_s1");
    add(1'b0, 8'h55, 3'd2, 8'hFF, "p55_s2");
    add(1'b0, 8'h55, 3'd3, 8'hF7, "p55_s3");
    add(1'b0, 8'h55, 3'd4, 8'hFF, "p55_s4");
    add(1'b0, 8'h55, 3'd5, 8'hDF, "p55_s5");
    add(1'b0, 8'h55, 3'd6, 8'hFF, "p55_s6");
    add(1'b0, 8'h55, 3'd7, 8'h7F, "p55_s7");
    // Other single-bit patterns
    add(1'b0, 8'h80, 3'd7, 8'hFF, "x80_s7");
    add(1'b0, 8'h7F, 3'd7, 8'h7F, "x7f_s7");
    add(1'b0, 8'hEF, 3'd4, 8'hEF, "xef_s4");
    add(1'b0, 8'hEF, 3'd3, 8'hFF, "xef_s3");
    add(1'b0, 8'hFB, 3'd2, 8'hFB, "xfb_s2");
    add(1'b0, 8'hBF, 3'd6, 8'hBF, "xbf_s6");

    have_prev = 1'b0;
    prev = 8'hFF;
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].data, vecs[i].sel, vecs[i].exp, vecs[i].name, have_prev, prev);
      prev = vecs[i].exp;
      have_prev = 1'b1;
    end

    // Reset mid-stream during the 55 sweep, release on sel 5
    step(1'b0, 8'h55, 3'd1, 8'hFD, "mid_s1", 1'b1, prev);
    step(1'b0, 8'h55, 3'd2, 8'hFF, "mid_s2", 1'b1, 8'hFD);
    step(1'b1, 8'h55, 3'd3, 8'hFF, "mid_rst_s3", 1'b1, 8'hFF);
    step(1'b0, 8'h55, 3'd5, 8'hDF, "mid_rel_s5", 1'b1, 8'hFF);
    step(1'b0, 8'h55, 3'd7, 8'h7F, "mid_s7", 1'b1, 8'hDF);

    // Long reset with moving inputs: held idle, then routing resumes at release
    step(1'b1, 8'h00, 3'd0, 8'hFF, "lrst_0", 1'b1, 8'h7F);
    step(1'b1, 8'h00, 3'd5, 8'hFF, "lrst_1", 1'b1, 8'hFF);
    step(1'b1, 8'h00, 3'd7, 8'hFF, "lrst_2", 1'b1, 8'hFF);
    step(1'b0, 8'h00, 3'd2, 8'hFB, "lrst_rel", 1'b1, 8'hFF);

    // Data and select change together every cycle
    step(1'b0, 8'hF7, 3'd3, 8'hF7, "sim_a", 1'b1, 8'hFB);
    step(1'b0, 8'hFD, 3'd1, 8'hFD, "sim_b", 1'b1, 8'hF7);
    step(1'b0, 8'hFD, 3'd6, 8'hFF, "sim_c", 1'b1, 8'hFD);
    step(1'b0, 8'h00, 3'd6, 8'hBF, "sim_d", 1'b1, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
